// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared types and widths for the data-memory arbiter slice.
//   - ADDR_W / DATA_W / MASK_W : word address, data and byte-enable widths
//     of the dmem macro port.
//   - arb_state_t : arbiter FSM states (free round-robin vs. locked burst).
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam int ARB_ST_WIDTH = 1;

  typedef enum logic [ARB_ST_WIDTH-1:0] {
    ARB_ST_IDLE   = 1'b0,
    ARB_ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Scans the request vector
//   starting at i_ptr and wrapping modulo N; the first set request wins.
//   Ports:
//     i_req  [N]      request vector
//     i_ptr  [PTR_W]  index with highest priority this cycle
//     o_gnt  [N]      one-hot winner (all zero when nobody requests)
//     o_idx  [PTR_W]  binary index of the winner (0 when nobody requests)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Walk the candidates in priority order ptr, ptr+1, ... and keep the first
  // one that is requesting. The sum is one bit wider so the modulo-N wrap
  // works for non-power-of-two N as well.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N)) begin
        sum = sum - (PTR_W+1)'(N);
      end
      cand = sum[PTR_W-1:0];
      if (!found && i_req[cand]) begin
        found       = 1'b1;
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port, word-addressed dmem between N_REQ requesters
//   (index 0 = core LSU). Round-robin arbitration, zero-latency grant, locked
//   bursts capped at LOCK_MAX beats, read data returned the cycle after the
//   granted read (dmem has 1-cycle synchronous read latency).
//   Ports:
//     clk, rst                  clock, async active-high reset
//     i_req/i_lock/i_we [N]     per-requester request, burst lock, write
//     i_addr/i_wdata/i_mask     packed per-requester address, data, bytes
//     o_gnt [N]                 one-hot beat accept (combinational)
//     o_rvalid [N]              one-hot read response valid (registered)
//     o_rdata                   read data, straight from the memory
//     o_mem_*                   memory address/data/write-enable/mask
//     i_mem_data                memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int LOCK_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_lock,
  input  logic [N_REQ-1:0]        i_we,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  input  logic [N_REQ*DATA_W-1:0] i_wdata,
  input  logic [N_REQ*MASK_W-1:0] i_mask,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]       o_rdata,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [DATA_W-1:0]       o_mem_data,
  output logic                    o_mem_we,
  output logic [MASK_W-1:0]       o_mem_mask,
  input  logic [DATA_W-1:0]       i_mem_data
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] beat_cnt;

  logic             locked;
  logic             owner_beat;
  logic             lock_drop;
  logic [PTR_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] win_idx;
  logic             any_gnt;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(N_REQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  assign locked     = (state == ARB_ST_LOCKED);
  assign owner_beat = locked & i_req[owner];
  assign lock_drop  = locked & ~i_req[owner];

  // An owner that stops requesting gives up the lock at once, and the rest
  // arbitrate in the same cycle as if the burst had ended normally.
  assign pick_ptr = lock_drop ? next_idx(owner) : ptr;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req (i_req),
    .i_ptr (pick_ptr),
    .o_gnt (pick_gnt),
    .o_idx (pick_idx)
  );

  // A live burst owner bypasses the picker. Reset forces the grant low
  // combinationally so nothing reaches the memory while rst is high.
  always_comb begin
    gnt     = pick_gnt;
    win_idx = pick_idx;
    if (owner_beat) begin
      gnt        = '0;
      gnt[owner] = 1'b1;
      win_idx    = owner;
    end
    if (rst) begin
      gnt = '0;
    end
  end

  assign o_gnt   = gnt;
  assign any_gnt = |gnt;
  assign o_rdata = i_mem_data;

  // Steer the granted requester's beat onto the memory port; with no grant
  // the port is parked at zero.
  always_comb begin
    o_mem_addr = '0;
    o_mem_data = '0;
    o_mem_mask = '0;
    o_mem_we   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        o_mem_addr = i_addr[k*ADDR_W +: ADDR_W];
        o_mem_data = i_wdata[k*DATA_W +: DATA_W];
        o_mem_mask = i_mask[k*MASK_W +: MASK_W];
        o_mem_we   = i_we[k];
      end
    end
  end

  // Arbitration FSM. beat_cnt holds the beats already granted in the burst,
  // so the beat that brings it to LOCK_MAX is granted and then releases.
  // The read response register sits here too: a granted read gets its
  // rvalid one cycle later, lining up with the memory's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      o_rvalid <= '0;
    end else begin
      o_rvalid <= gnt & ~i_we;
      if (owner_beat) begin
        if (!i_lock[owner] || beat_cnt == CNT_W'(LOCK_MAX - 1)) begin
          state    <= ARB_ST_IDLE;
          ptr      <= next_idx(owner);
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else begin
        state    <= ARB_ST_IDLE;
        ptr      <= pick_ptr;
        beat_cnt <= '0;
        if (any_gnt) begin
          if (i_lock[win_idx] && LOCK_MAX > 1) begin
            state    <= ARB_ST_LOCKED;
            owner    <= win_idx;
            beat_cnt <= CNT_W'(1);
          end else begin
            ptr <= next_idx(win_idx);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter (N_REQ=2, LOCK_MAX=8). A small
//   synchronous memory sits behind the arbiter; a behavioural model tracks
//   priority, lock ownership and a reference copy of memory, and every cycle
//   the DUT's grant, memory port and read response are compared with it.
//   Directed scenarios come first, then randomized requester traffic.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int LM = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      i_req, i_lock, i_we;
  logic [N*30-1:0]   i_addr;
  logic [N*32-1:0]   i_wdata;
  logic [N*4-1:0]    i_mask;
  logic [N-1:0]      o_gnt, o_rvalid;
  logic [31:0]       o_rdata, o_mem_data, i_mem_data;
  logic [29:0]       o_mem_addr;
  logic              o_mem_we;
  logic [3:0]        o_mem_mask;

  always #5 clk = ~clk;

  dmem_arbiter #(.N_REQ(N), .LOCK_MAX(LM)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_lock     (i_lock),
    .i_we       (i_we),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_mask     (i_mask),
    .o_gnt      (o_gnt),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_we   (o_mem_we),
    .o_mem_mask (o_mem_mask),
    .i_mem_data (i_mem_data)
  );

  function automatic logic [31:0] initVal(input int i);
    if (i < 16) begin
      return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    end
    return 32'h0;
  endfunction

  // Memory behind the arbiter: byte-masked writes, one-cycle read latency,
  // read-before-write within a cycle. Preloaded on the first clock edge.
  logic [31:0] env_mem [64];
  logic [31:0] mem_rd;
  logic        env_loaded = 1'b0;
  assign i_mem_data = mem_rd;

  always @(posedge clk) begin
    if (!env_loaded) begin
      for (int i = 0; i < 64; i++) begin
        env_mem[i] <= initVal(i);
      end
      env_loaded <= 1'b1;
    end else begin
      if (o_mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (o_mem_mask[b]) begin
            env_mem[o_mem_addr[5:0]][8*b +: 8] <= o_mem_data[8*b +: 8];
          end
        end
      end
      mem_rd <= env_mem[o_mem_addr[5:0]];
    end
  end

  // Requester-side stimulus state.
  logic        req_a   [N];
  logic        lock_a  [N];
  logic        we_a    [N];
  logic [29:0] addr_a  [N];
  logic [31:0] wdata_a [N];
  logic [3:0]  mask_a  [N];

  // Reference model state.
  int          m_ptr, m_owner, m_beats;
  bit          m_locked;
  logic [31:0] ref_mem [64];
  logic [N-1:0] exp_rvalid;
  logic [31:0]  exp_rdata;

  int          checks = 0;
  int          failures = 0;
  logic [N-1:0] obs_gnt;
  logic [31:0]  obs_rdata;
  int          w;
  int          cnt1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < N; k++) begin
      i_req[k]             = req_a[k];
      i_lock[k]            = lock_a[k];
      i_we[k]              = we_a[k];
      i_addr[k*30 +: 30]   = addr_a[k];
      i_wdata[k*32 +: 32]  = wdata_a[k];
      i_mask[k*4 +: 4]     = mask_a[k];
    end
  endtask

  task automatic setReq(input int k, input logic r, input logic l, input logic we_v,
                        input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    req_a[k] = r; lock_a[k] = l; we_a[k] = we_v;
    addr_a[k] = a; wdata_a[k] = d; mask_a[k] = m;
  endtask

  task automatic modelReset();
    m_ptr = 0; m_owner = 0; m_beats = 0; m_locked = 1'b0;
    exp_rvalid = '0;
  endtask

  // Who should be granted now: a requesting lock owner keeps the port,
  // otherwise the first requester found scanning round-robin from the
  // current priority (which moves past an owner that just walked away).
  function automatic int modelWinner();
    int base;
    if (m_locked && req_a[m_owner]) return m_owner;
    base = m_locked ? (m_owner + 1) % N : m_ptr;
    for (int i = 0; i < N; i++) begin
      if (req_a[(base + i) % N]) return (base + i) % N;
    end
    return -1;
  endfunction

  task automatic modelAdvance(input int win);
    exp_rvalid = '0;
    if (win >= 0) begin
      if (we_a[win]) begin
        for (int b = 0; b < 4; b++) begin
          if (mask_a[win][b]) ref_mem[addr_a[win][5:0]][8*b +: 8] = wdata_a[win][8*b +: 8];
        end
      end else begin
        exp_rvalid[win] = 1'b1;
        exp_rdata = ref_mem[addr_a[win][5:0]];
      end
    end
    if (m_locked && win == m_owner) begin
      m_beats++;
      if (!lock_a[win] || m_beats == LM) begin
        m_locked = 1'b0;
        m_ptr = (win + 1) % N;
      end
    end else begin
      if (m_locked) begin
        m_locked = 1'b0;
        m_ptr = (m_owner + 1) % N;
      end
      if (win >= 0) begin
        if (lock_a[win] && LM > 1) begin
          m_locked = 1'b1; m_owner = win; m_beats = 1;
        end else begin
          m_ptr = (win + 1) % N;
        end
      end
    end
  endtask

  task automatic compareOutputs(input int win);
    logic [N-1:0] eg;
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    checkOutput("gnt", o_gnt, eg);
    checkOutput("mem_we", o_mem_we, (win >= 0) ? we_a[win] : 1'b0);
    checkOutput("mem_addr", o_mem_addr, (win >= 0) ? addr_a[win] : 30'h0);
    checkOutput("mem_data", o_mem_data, (win >= 0) ? wdata_a[win] : 32'h0);
    checkOutput("mem_mask", o_mem_mask, (win >= 0) ? mask_a[win] : 4'h0);
    checkOutput("rvalid", o_rvalid, exp_rvalid);
    if (|exp_rvalid) checkOutput("rdata", o_rdata, exp_rdata);
  endtask

  // One arbitration cycle: sample at the falling edge, advance the model at
  // the rising edge, return just after it so new stimulus can be applied.
  task automatic stepCycle(output int win);
    @(negedge clk);
    win = modelWinner();
    obs_gnt = o_gnt;
    obs_rdata = o_rdata;
    compareOutputs(win);
    @(posedge clk);
    modelAdvance(win);
    #1;
  endtask

  task automatic redraw(input int k, input int start_pct);
    req_a[k]   = ($urandom_range(0, 99) < start_pct);
    lock_a[k]  = ($urandom_range(0, 99) < 40);
    we_a[k]    = 1'($urandom_range(0, 1));
    addr_a[k]  = 30'($urandom_range(0, 63));
    wdata_a[k] = $urandom;
    mask_a[k]  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = initVal(i);
    modelReset();
    exp_rdata = '0;

    // Reset state with both requesting, one of them a write.
    setReq(0, 1'b1, 1'b0, 1'b0, 30'd3, 32'h0, 4'hF);
    setReq(1, 1'b1, 1'b0, 1'b1, 30'd5, 32'h1234_5678, 4'hF);
    applyStimulus();
    #2;
    checkOutput("rst_gnt", o_gnt, 2'b00);
    checkOutput("rst_rvalid", o_rvalid, 2'b00);
    checkOutput("rst_mem_we", o_mem_we, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    we_a[1] = 1'b0;
    applyStimulus();
    rst = 1'b0;

    // Alternating round-robin reads.
    stepCycle(w); checkOutput("t1_gnt_a", obs_gnt, 2'b01);
    stepCycle(w); checkOutput("t1_gnt_b", obs_gnt, 2'b10);
    checkOutput("t1_rdata", obs_rdata, initVal(3));
    stepCycle(w); checkOutput("t1_gnt_c", obs_gnt, 2'b01);
    checkOutput("t1_rdata2", obs_rdata, initVal(5));
    req_a[0] = 1'b0; req_a[1] = 1'b0; applyStimulus();
    stepCycle(w);

    // Masked write then read back.
    setReq(0, 1'b1, 1'b0, 1'b1, 30'h10, 32'hDEAD_BEEF, 4'b0011); applyStimulus();
    stepCycle(w);
    setReq(0, 1'b1, 1'b0, 1'b0, 30'h10, 32'h0, 4'hF); applyStimulus();
    stepCycle(w);
    req_a[0] = 1'b0; applyStimulus();
    stepCycle(w);
    checkOutput("t2_rdata", obs_rdata, 32'h0000_BEEF);

    // Four-beat locked burst by requester 1 while requester 0 waits.
    setReq(0, 1'b1, 1'b0, 1'b0, 30'd1, 32'h0, 4'hF);
    for (int b = 1; b <= 4; b++) begin
      setReq(1, 1'b1, (b < 4), 1'b1, 30'(20 + b), 32'hA0A0_0000 + 32'(b), 4'hF);
      applyStimulus();
      stepCycle(w);
      checkOutput("t3_burst", obs_gnt, 2'b10);
    end
    setReq(1, 1'b1, 1'b0, 1'b0, 30'd2, 32'h0, 4'hF); applyStimulus();
    stepCycle(w); checkOutput("t3_after", obs_gnt, 2'b01);
    req_a[0] = 1'b0;

    // Lock held forever: capped at LM beats, then requester 0 gets in.
    lock_a[1] = 1'b1; req_a[0] = 1'b1; applyStimulus();
    cnt1 = 0;
    for (int c = 0; c < LM + 1; c++) begin
      stepCycle(w);
      if (obs_gnt == 2'b10) cnt1++;
    end
    checkOutput("t4_beats", 64'(cnt1), 64'(LM));
    checkOutput("t4_release", obs_gnt, 2'b01);
    req_a[0] = 1'b0; req_a[1] = 1'b0; applyStimulus();
    stepCycle(w);

    // Owner walks away mid-lock; the waiter is granted in that same cycle.
    setReq(1, 1'b1, 1'b1, 1'b0, 30'd7, 32'h0, 4'hF);
    setReq(0, 1'b1, 1'b0, 1'b0, 30'd8, 32'h0, 4'hF);
    applyStimulus();
    stepCycle(w); checkOutput("t5_lock", obs_gnt, 2'b10);
    req_a[1] = 1'b0; applyStimulus();
    stepCycle(w); checkOutput("t5_drop", obs_gnt, 2'b01);
    req_a[0] = 1'b0; applyStimulus();
    stepCycle(w);

    // Reset right after a granted read kills the response.
    setReq(0, 1'b1, 1'b0, 1'b0, 30'd4, 32'h0, 4'hF); applyStimulus();
    stepCycle(w); checkOutput("t6_read", obs_gnt, 2'b01);
    setReq(1, 1'b1, 1'b0, 1'b1, 30'd9, 32'h5555_AAAA, 4'hF); applyStimulus();
    rst = 1'b1;
    #1;
    checkOutput("t6_rvalid", o_rvalid, 2'b00);
    checkOutput("t6_gnt", o_gnt, 2'b00);
    checkOutput("t6_mem_we", o_mem_we, 1'b0);
    modelReset();
    @(posedge clk); #1;
    rst = 1'b0;
    stepCycle(w); checkOutput("t6_first", obs_gnt, 2'b01);
    req_a[0] = 1'b0; req_a[1] = 1'b0; applyStimulus();
    stepCycle(w);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (w >= 0) redraw(w, 60);
      for (int k = 0; k < N; k++) begin
        if (!req_a[k]) redraw(k, 30);
      end
      applyStimulus();
      stepCycle(w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
